// File: rtl/md_sched_pkg.sv
// ---------------------------------------------------------------------------
// md_sched_pkg
// Shared definitions for the mult/div scheduler:
//   - md_state_e : scheduler FSM encoding (IDLE=0, START=1, BUSY=2, DONE=3)
//   - RSTATUS    : register that receives mult/div exception codes
//   - MULT_EXC / DIV_EXC : exception codes written to RSTATUS
//   - exc_code() : picks the exception code for an operation kind
// ---------------------------------------------------------------------------
package md_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    BUSY  = 2'd2,
    DONE  = 2'd3
  } md_state_e;

  localparam logic [4:0]  RSTATUS  = 5'd30;
  localparam logic [31:0] MULT_EXC = 32'd4;
  localparam logic [31:0] DIV_EXC  = 32'd5;

  function automatic logic [31:0] exc_code(input logic is_div);
    return is_div ? DIV_EXC : MULT_EXC;
  endfunction

endpackage

// File: rtl/md_wport_arb.sv
// ---------------------------------------------------------------------------
// md_wport_arb
// Combinational owner of the single regfile write port. The pipeline MW
// writeback always has priority; the buffered mult/div result is granted
// only in cycles where the pipeline is not writing. Writes to r0 are
// suppressed for both sources.
//
// Ports:
//   wb_valid/wb_reg/wb_data    in  : pipeline MW writeback request
//   buf_valid/buf_reg/buf_data in  : buffered mult/div result waiting to write
//   buf_grant                  out : buffer owns the port this cycle
//   write_en/write_reg/write_data out : regfile write port
// ---------------------------------------------------------------------------
module md_wport_arb (
  input  logic        wb_valid,
  input  logic [4:0]  wb_reg,
  input  logic [31:0] wb_data,
  input  logic        buf_valid,
  input  logic [4:0]  buf_reg,
  input  logic [31:0] buf_data,
  output logic        buf_grant,
  output logic        write_en,
  output logic [4:0]  write_reg,
  output logic [31:0] write_data
);

  always_comb begin
    buf_grant  = buf_valid & ~wb_valid;
    write_reg  = wb_reg;
    write_data = wb_data;
    if (buf_grant) begin
      write_reg  = buf_reg;
      write_data = buf_data;
    end
    // The grant still counts for an r0 destination, so the scheduler retires
    // the operation even though nothing reaches the regfile.
    write_en = (wb_valid | buf_grant) & (write_reg != 5'd0);
  end

endmodule

// File: rtl/multdiv_scheduler.sv
// ---------------------------------------------------------------------------
// multdiv_scheduler
// Sequences one outstanding mult/div operation next to the 5-stage pipeline:
// accepts an issue from execute, pulses the multdiv start, holds operands,
// stalls the front end while busy, flags RAW hazards on the pending rd and
// merges the result (or exception code into RSTATUS_REG) into the regfile
// write port without displacing pipeline writebacks.
//
// Handshake: an issue transfers on a rising edge where issue_valid=1 and
// issue_ready=1 (scheduler IDLE). issue_valid while not IDLE is ignored, so
// execute keeps holding the instruction under stall until accepted.
//
// Optional feature macro: MD_TIMEOUT_EN -- when defined, BUSY aborts after
// TIMEOUT cycles without md_resultRDY and writes the exception code.
//
// Ports:
//   clock, reset (async, active-low)
//   issue_valid/issue_is_div/issue_rd/issue_a/issue_b in, issue_ready out
//   md_ctrl_mult/md_ctrl_div out  : one-cycle start pulses
//   md_operand_a/md_operand_b out : operands held until next accepted issue
//   md_result/md_exception/md_resultRDY in : multdiv completion
//   dec_src_a/dec_src_b in, hazard/stall out
//   wb_valid/wb_reg/wb_data in    : pipeline writeback request
//   ctrl_writeEnable/ctrl_writeReg/data_writeReg out : regfile write port
//   dbg_state out                 : current FSM state
// ---------------------------------------------------------------------------
module multdiv_scheduler
  import md_sched_pkg::*;
#(
  parameter int TIMEOUT     = 40,
  parameter int RSTATUS_REG = int'(RSTATUS)
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        issue_valid,
  input  logic        issue_is_div,
  input  logic [4:0]  issue_rd,
  input  logic [31:0] issue_a,
  input  logic [31:0] issue_b,
  output logic        issue_ready,
  output logic        md_ctrl_mult,
  output logic        md_ctrl_div,
  output logic [31:0] md_operand_a,
  output logic [31:0] md_operand_b,
  input  logic [31:0] md_result,
  input  logic        md_exception,
  input  logic        md_resultRDY,
  input  logic [4:0]  dec_src_a,
  input  logic [4:0]  dec_src_b,
  output logic        hazard,
  output logic        stall,
  input  logic        wb_valid,
  input  logic [4:0]  wb_reg,
  input  logic [31:0] wb_data,
  output logic        ctrl_writeEnable,
  output logic [4:0]  ctrl_writeReg,
  output logic [31:0] data_writeReg,
  output md_state_e   dbg_state
);

  localparam logic [4:0] RST_RD = 5'(RSTATUS_REG);

  md_state_e   state_q, state_d;
  logic        is_div_q, is_div_d;
  logic [4:0]  rd_q, rd_d;
  logic [31:0] op_a_q, op_a_d;
  logic [31:0] op_b_q, op_b_d;
  logic        mult_q, mult_d;
  logic        div_q, div_d;
  logic [4:0]  buf_reg_q, buf_reg_d;
  logic [31:0] buf_data_q, buf_data_d;
  logic        buf_grant;
  logic        timeout_hit;
  logic [4:0]  pend_rd;

`ifdef MD_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt_q, cnt_d;

  // cnt_q counts BUSY cycles already completed; the TIMEOUT-th BUSY cycle
  // is the last one, so DONE begins TIMEOUT+1 cycles after the start pulse.
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == START) begin
      cnt_d = '0;
    end else if (state_q == BUSY) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign timeout_hit = (state_q == BUSY) && (cnt_q == CW'(TIMEOUT - 1));
`else
  logic [31:0] unused_timeout;
  assign unused_timeout = TIMEOUT;
  assign timeout_hit    = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    is_div_d   = is_div_q;
    rd_d       = rd_q;
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    buf_reg_d  = buf_reg_q;
    buf_data_d = buf_data_q;
    mult_d     = 1'b0;
    div_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (issue_valid) begin
          is_div_d = issue_is_div;
          rd_d     = issue_rd;
          op_a_d   = issue_a;
          op_b_d   = issue_b;
          // Start pulse is registered here so it is high exactly in START.
          mult_d   = ~issue_is_div;
          div_d    = issue_is_div;
          state_d  = START;
        end
      end
      START: state_d = BUSY;
      BUSY: begin
        if (md_resultRDY || timeout_hit) begin
          state_d = DONE;
          if (md_resultRDY && !md_exception) begin
            buf_reg_d  = rd_q;
            buf_data_d = md_result;
          end else begin
            buf_reg_d  = RST_RD;
            buf_data_d = exc_code(is_div_q);
          end
        end
      end
      DONE: begin
        if (buf_grant) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      is_div_q   <= 1'b0;
      rd_q       <= '0;
      op_a_q     <= '0;
      op_b_q     <= '0;
      mult_q     <= 1'b0;
      div_q      <= 1'b0;
      buf_reg_q  <= '0;
      buf_data_q <= '0;
`ifdef MD_TIMEOUT_EN
      cnt_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      is_div_q   <= is_div_d;
      rd_q       <= rd_d;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      mult_q     <= mult_d;
      div_q      <= div_d;
      buf_reg_q  <= buf_reg_d;
      buf_data_q <= buf_data_d;
`ifdef MD_TIMEOUT_EN
      cnt_q      <= cnt_d;
`endif
    end
  end

  md_wport_arb u_wport_arb (
    .wb_valid   (wb_valid),
    .wb_reg     (wb_reg),
    .wb_data    (wb_data),
    .buf_valid  (state_q == DONE),
    .buf_reg    (buf_reg_q),
    .buf_data   (buf_data_q),
    .buf_grant  (buf_grant),
    .write_en   (ctrl_writeEnable),
    .write_reg  (ctrl_writeReg),
    .write_data (data_writeReg)
  );

  // Once the result is buffered, the register actually about to be written
  // (rd or RSTATUS on exception) is the one decode must wait for.
  assign pend_rd = (state_q == DONE) ? buf_reg_q : rd_q;

  assign hazard       = (state_q != IDLE) && (pend_rd != 5'd0) &&
                        ((dec_src_a == pend_rd) || (dec_src_b == pend_rd));
  assign stall        = (state_q != IDLE) || hazard;
  assign issue_ready  = (state_q == IDLE);
  assign md_ctrl_mult = mult_q;
  assign md_ctrl_div  = div_q;
  assign md_operand_a = op_a_q;
  assign md_operand_b = op_b_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_multdiv_scheduler.sv
// ---------------------------------------------------------------------------
// tb_multdiv_scheduler
// Directed scenarios followed by randomized mult/div traffic with random
// pipeline writebacks, decode sources and stray completions. A behavioural
// model tracks the outstanding operation as a phase plus a pending write;
// a scoreboard queue holds the write expected on the regfile port.
// ---------------------------------------------------------------------------
module tb_multdiv_scheduler;
  import md_sched_pkg::*;

  localparam int TIMEOUT = 40;
  localparam int W       = 37;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic        issue_valid, issue_is_div;
  logic [4:0]  issue_rd;
  logic [31:0] issue_a, issue_b;
  logic        issue_ready;
  logic        md_ctrl_mult, md_ctrl_div;
  logic [31:0] md_operand_a, md_operand_b;
  logic [31:0] md_result;
  logic        md_exception, md_resultRDY;
  logic [4:0]  dec_src_a, dec_src_b;
  logic        hazard, stall;
  logic        wb_valid;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;
  logic        ctrl_writeEnable;
  logic [4:0]  ctrl_writeReg;
  logic [31:0] data_writeReg;
  md_state_e   dbg_state;

  multdiv_scheduler #(.TIMEOUT(TIMEOUT), .RSTATUS_REG(30)) dut (
    .clock(clock), .reset(reset),
    .issue_valid(issue_valid), .issue_is_div(issue_is_div), .issue_rd(issue_rd),
    .issue_a(issue_a), .issue_b(issue_b), .issue_ready(issue_ready),
    .md_ctrl_mult(md_ctrl_mult), .md_ctrl_div(md_ctrl_div),
    .md_operand_a(md_operand_a), .md_operand_b(md_operand_b),
    .md_result(md_result), .md_exception(md_exception), .md_resultRDY(md_resultRDY),
    .dec_src_a(dec_src_a), .dec_src_b(dec_src_b), .hazard(hazard), .stall(stall),
    .wb_valid(wb_valid), .wb_reg(wb_reg), .wb_data(wb_data),
    .ctrl_writeEnable(ctrl_writeEnable), .ctrl_writeReg(ctrl_writeReg),
    .data_writeReg(data_writeReg), .dbg_state(dbg_state)
  );

  // ---------------- checking ----------------
  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // m_phase: 0 no operation, 1 start-pulse cycle, 2 waiting for result,
  // 3 result held until the first cycle without pipeline writeback.
  int          m_phase;
  int          m_wait;
  logic        m_div;
  logic [4:0]  m_rd;
  logic [31:0] m_a, m_b;
  logic [4:0]  m_wreg;
  logic [31:0] m_wdata;
  logic [W-1:0] exp_q[$];

  int cfg_wb_pct   = 0;
  bit cfg_rand_dec = 1'b0;

  task automatic m_reset();
    m_phase = 0; m_wait = 0; m_div = 1'b0; m_rd = '0;
    m_a = '0; m_b = '0; m_wreg = '0; m_wdata = '0;
    exp_q.delete();
  endtask

  // Check the current cycle, then advance the model across the next edge.
  task automatic tick();
    logic [4:0]   pr;
    logic         exp_hz;
    logic [W-1:0] w;
    #1;
    pr     = (m_phase == 3) ? m_wreg : m_rd;
    exp_hz = (m_phase != 0) && (pr != 5'd0) && (dec_src_a == pr || dec_src_b == pr);
    chk("issue_ready", issue_ready, m_phase == 0);
    chk("md_ctrl_mult", md_ctrl_mult, (m_phase == 1) && !m_div);
    chk("md_ctrl_div", md_ctrl_div, (m_phase == 1) && m_div);
    chk("md_operand_a", md_operand_a, m_a);
    chk("md_operand_b", md_operand_b, m_b);
    chk("hazard", hazard, exp_hz);
    chk("stall", stall, exp_hz || (m_phase != 0));
    // The pipeline write always goes out; the held result waits for a gap.
    if (wb_valid) begin
      if (wb_reg != 5'd0) exp_q.push_back({wb_reg, wb_data});
    end else if (m_phase == 3) begin
      if (m_wreg != 5'd0) exp_q.push_back({m_wreg, m_wdata});
    end
    chk("write_enable", ctrl_writeEnable, exp_q.size() != 0);
    if (exp_q.size() != 0) begin
      w = exp_q.pop_front();
      if (ctrl_writeEnable) chk("write_reg_data", {ctrl_writeReg, data_writeReg}, w);
    end
    @(posedge clock);
    case (m_phase)
      0: if (issue_valid) begin
           m_div = issue_is_div; m_rd = issue_rd; m_a = issue_a; m_b = issue_b;
           m_phase = 1;
         end
      1: begin m_phase = 2; m_wait = 0; end
      2: if (md_resultRDY) begin
           m_wreg  = md_exception ? 5'd30 : m_rd;
           m_wdata = md_exception ? (m_div ? 32'd5 : 32'd4) : md_result;
           m_phase = 3;
         end else begin
           m_wait++;
`ifdef MD_TIMEOUT_EN
           if (m_wait == TIMEOUT) begin
             m_wreg  = 5'd30;
             m_wdata = m_div ? 32'd5 : 32'd4;
             m_phase = 3;
           end
`endif
         end
      3: if (!wb_valid) m_phase = 0;
      default: m_phase = 0;
    endcase
    @(negedge clock);
  endtask

  // ---------------- driver tasks ----------------
  task automatic rand_side();
    wb_valid = ($urandom_range(0, 99) < cfg_wb_pct);
    wb_reg   = 5'($urandom_range(0, 31));
    wb_data  = $urandom;
    if (cfg_rand_dec) begin
      dec_src_a = ($urandom_range(0, 2) == 0) ? m_rd : 5'($urandom_range(0, 31));
      dec_src_b = ($urandom_range(0, 2) == 0) ? m_wreg : 5'($urandom_range(0, 31));
    end
    // Junk issues while busy must be ignored and must not disturb operands.
    if (m_phase != 0) begin
      issue_valid  = 1'($urandom_range(0, 1));
      issue_is_div = 1'($urandom_range(0, 1));
      issue_rd     = 5'($urandom_range(0, 31));
      issue_a      = $urandom;
      issue_b      = $urandom;
    end else begin
      issue_valid = 1'b0;
    end
    // Stray completions outside the waiting phase must be ignored.
    md_resultRDY = (m_phase != 2) && ($urandom_range(0, 7) == 0);
    md_exception = 1'($urandom_range(0, 1));
    md_result    = $urandom;
  endtask

  task automatic run_op(input logic is_div, input logic [4:0] rd, input logic [31:0] a,
                        input logic [31:0] b, input int lat, input logic exc,
                        input logic [31:0] res);
    int guard;
    guard = 0;
    while (m_phase != 0 && guard < 60) begin
      rand_side();
      tick();
      guard++;
    end
    chk("drain_bound", issue_ready, 1'b1);
    rand_side();
    md_resultRDY = 1'b0;
    issue_valid = 1'b1; issue_is_div = is_div; issue_rd = rd; issue_a = a; issue_b = b;
    tick();                       // accepted at this edge
    rand_side(); md_resultRDY = 1'b0;
    tick();                       // start pulse cycle
    repeat (lat) begin
      rand_side();
      if (m_phase == 2) md_resultRDY = 1'b0;
      tick();
    end
    rand_side();
    md_resultRDY = 1'b1; md_exception = exc; md_result = res;
    tick();
    md_resultRDY = 1'b0; md_exception = 1'b0;
  endtask

  task automatic quiet();
    issue_valid = 1'b0; md_resultRDY = 1'b0; md_exception = 1'b0;
    wb_valid = 1'b0; wb_reg = '0; wb_data = '0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    m_reset();
    reset = 1'b0;
    issue_valid = 1'b0; issue_is_div = 1'b0; issue_rd = '0; issue_a = '0; issue_b = '0;
    md_result = '0; md_exception = 1'b0; md_resultRDY = 1'b0;
    dec_src_a = '0; dec_src_b = '0;
    wb_valid = 1'b1; wb_reg = 5'd3; wb_data = 32'h55;
    #1;
    chk("rst_issue_ready", issue_ready, 1'b1);
    chk("rst_mult", md_ctrl_mult, 1'b0);
    chk("rst_div", md_ctrl_div, 1'b0);
    chk("rst_operand_a", md_operand_a, 32'd0);
    chk("rst_operand_b", md_operand_b, 32'd0);
    chk("rst_hazard", hazard, 1'b0);
    chk("rst_stall", stall, 1'b0);
    chk("rst_wport", {ctrl_writeEnable, ctrl_writeReg, data_writeReg}, {1'b1, 5'd3, 32'h55});
    repeat (2) @(negedge clock);
    reset = 1'b1;
    quiet();

    // Mult 6x7 -> r5, no writeback traffic.
    cfg_wb_pct = 0; cfg_rand_dec = 1'b0;
    run_op(1'b0, 5'd5, 32'd6, 32'd7, 3, 1'b0, 32'd42);
    quiet();
    tick();                       // r5=42 expected here
    tick();                       // back to idle

    // Div with exception -> r30=5, rd untouched.
    run_op(1'b1, 5'd12, 32'd100, 32'd0, 2, 1'b1, 32'hDEAD);
    quiet(); tick(); tick();

    // Mult to r7=9, pipeline writes r3=0x11 in the first DONE cycle.
    run_op(1'b0, 5'd7, 32'd3, 32'd3, 1, 1'b0, 32'd9);
    quiet();
    wb_valid = 1'b1; wb_reg = 5'd3; wb_data = 32'h11;
    tick();
    quiet(); tick(); tick();

    // Hazard on pending r8 via dec_src_b; then rd=0 with dec_src_a=0.
    dec_src_a = 5'd1; dec_src_b = 5'd8;
    run_op(1'b0, 5'd8, 32'd2, 32'd4, 2, 1'b0, 32'd8);
    quiet(); tick(); tick();
    dec_src_a = 5'd0; dec_src_b = 5'd0;
    run_op(1'b1, 5'd0, 32'd9, 32'd3, 2, 1'b0, 32'd3);
    quiet(); tick(); tick();

    // Reset asserted while waiting for the result.
    run_op(1'b1, 5'd20, 32'd50, 32'd5, 0, 1'b0, 32'd10);
    quiet(); tick();
    issue_valid = 1'b1; issue_is_div = 1'b0; issue_rd = 5'd21; issue_a = 32'hA; issue_b = 32'hB;
    tick(); quiet(); tick(); tick();    // now waiting for result
    dec_src_a = 5'd21;
    wb_valid = 1'b1; wb_reg = 5'd9; wb_data = 32'h99;
    reset = 1'b0;
    #1;
    chk("mid_rst_issue_ready", issue_ready, 1'b1);
    chk("mid_rst_mult", md_ctrl_mult, 1'b0);
    chk("mid_rst_operand_a", md_operand_a, 32'd0);
    chk("mid_rst_operand_b", md_operand_b, 32'd0);
    chk("mid_rst_hazard", hazard, 1'b0);
    chk("mid_rst_stall", stall, 1'b0);
    chk("mid_rst_wport", {ctrl_writeEnable, ctrl_writeReg, data_writeReg}, {1'b1, 5'd9, 32'h99});
    m_reset();
    @(negedge clock);
    reset = 1'b1;
    quiet();
    md_resultRDY = 1'b1; md_result = 32'h1234;
    tick();
    quiet(); tick();

    // Long wait: exceeds TIMEOUT when the timeout feature is built in.
    run_op(1'b0, 5'd11, 32'd1, 32'd1, 45, 1'b0, 32'd77);
    quiet(); tick(); tick();

    // Randomized traffic.
    cfg_wb_pct = 30; cfg_rand_dec = 1'b1;
    for (int i = 0; i < 30; i++) begin
      run_op(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom, $urandom,
             $urandom_range(0, 6), ($urandom_range(0, 7) == 0), $urandom);
    end
    cfg_wb_pct = 0;
    quiet();
    repeat (6) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
